// File: rtl/qif_spike_decoder_if.sv
// Bundle between the QIF membrane stream source/rate consumer and the spike decoder.
// The decoder takes the slave side. The environment takes the master side.
interface qif_spike_decoder_if;
   logic        en;
   logic [7:0]  v_mem;
   logic        spike;
   logic [23:0] isi;
   logic        isi_valid;
   logic [15:0] rate_count;
   logic        rate_valid;
   logic        rate_ready;
   logic        rate_overrun;

   modport master (
      output en, v_mem, rate_ready,
      input  spike, isi, isi_valid, rate_count, rate_valid, rate_overrun
   );

   modport slave (
      input  en, v_mem, rate_ready,
      output spike, isi, isi_valid, rate_count, rate_valid, rate_overrun
   );
endinterface

// File: rtl/qif_spike_decoder.sv
// Converts a QIF membrane stream back into numbers.
// It detects spikes with threshold/re-arm hysteresis, measures the ISI and reports a windowed firing rate.
module qif_spike_decoder #(
   parameter logic [7:0]  V_THRESH = 8'd200,
   parameter logic [7:0]  V_REARM  = 8'd64,
   parameter logic [23:0] WINDOW   = 24'd10_000_000
) (
   input logic clk,
   input logic rst,
   qif_spike_decoder_if.slave bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PEAK = 1'b1;

   logic [0:0]  state;
   logic [23:0] icnt;
   logic [23:0] wcnt;
   logic [15:0] scnt;
   logic        first_seen;

   logic        ev;
   logic        win_close;
   logic [23:0] icnt_inc;
   logic [15:0] scnt_inc;

   // ev is the registered-next spike: it fires on the same edge that enters PEAK
   assign ev        = bus.en && (state == ST_IDLE) && (bus.v_mem >= V_THRESH);
   assign win_close = bus.en && (wcnt == WINDOW - 24'd1);
   assign icnt_inc  = (icnt == 24'hFFFFFF) ? icnt : icnt + 24'd1;
   assign scnt_inc  = (ev && scnt != 16'hFFFF) ? scnt + 16'd1 : scnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         icnt             <= '0;
         wcnt             <= '0;
         scnt             <= '0;
         first_seen       <= 1'b0;
         bus.spike        <= 1'b0;
         bus.isi          <= '0;
         bus.isi_valid    <= 1'b0;
         bus.rate_count   <= '0;
         bus.rate_valid   <= 1'b0;
         bus.rate_overrun <= 1'b0;
      end else begin
         bus.spike     <= ev;
         bus.isi_valid <= ev && first_seen;

         if (bus.en) begin
            case (state)
               ST_IDLE: if (bus.v_mem >= V_THRESH) state <= ST_PEAK;
               ST_PEAK: if (bus.v_mem < V_REARM)   state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase

            if (ev) begin
               bus.isi    <= icnt_inc;
               icnt       <= '0;
               first_seen <= 1'b1;
            end else begin
               icnt <= icnt_inc;
            end

            // A spike on the closing edge is folded into the window being reported
            if (win_close) begin
               wcnt <= '0;
               scnt <= '0;
            end else begin
               wcnt <= wcnt + 24'd1;
               scnt <= scnt_inc;
            end
         end

         // A fresh result wins over a same-edge accept, so the consumer never loses it
         if (win_close) begin
            bus.rate_count <= scnt_inc;
            bus.rate_valid <= 1'b1;
            if (bus.rate_valid && !bus.rate_ready) bus.rate_overrun <= 1'b1;
         end else if (bus.rate_valid && bus.rate_ready) begin
            bus.rate_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/qif_spike_decoder.md
Name: qif_spike_decoder

Overview:
- Sits downstream of the QIF neuron and reads the neuron's 8-bit membrane output stream.
- Detects spikes on that stream using threshold-plus-hysteresis.
- Measures inter-spike interval (ISI) in clock cycles.
- Accumulates spikes over a fixed window and reports a firing rate over a valid/ready handshake, so the neuron's output can be turned back into a number.

Parameters:
- V_THRESH, 8'd200: spike detected when v_mem >= V_THRESH while disarmed-from-peak (state IDLE).
- V_REARM, 8'd64: detector re-arms when v_mem < V_REARM. Must satisfy V_REARM < V_THRESH.
- WINDOW, 24'd10_000_000: rate window length in enabled clock cycles, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable. When low, every state, counter and output holds.
- v_mem  input  8  membrane potential from the neuron, unsigned.
- spike  output  1  one-cycle pulse per detected spike.
- isi  output  24  cycles between the last two spikes, saturating.
- isi_valid  output  1  one-cycle pulse coincident with spike, from the second spike after reset onward.
- rate_count  output  16  spikes counted in the last completed window.
- rate_valid  output  1  rate_count holds an unconsumed result.
- rate_ready  input  1  consumer accepts rate_count when rate_valid && rate_ready.
- rate_overrun  output  1  sticky: a window result was overwritten before being accepted.

Behaviour:
- Reset values: all outputs 0, internal counters 0, FSM in IDLE, first-spike flag cleared.
- Detector FSM, 2 states, evaluated only when en=1:
  - IDLE -> PEAK when v_mem >= V_THRESH. spike=1 in the cycle after that edge. Latency is 1 cycle, output registered.
  - PEAK -> IDLE when v_mem < V_REARM. No output.
  - Otherwise the FSM holds. Values between the two thresholds never re-trigger.
  - Internal event e = registered-next spike, i.e. asserted on the same edge that enters PEAK.
- ISI counter icnt, 24 bits:
  - Increments every enabled cycle, saturating at 24'hFFFFFF.
  - On e: isi <= icnt+1, saturating. isi_valid <= 1 only if at least one earlier spike occurred since reset. icnt <= 0. Set the first-spike flag.
  - isi holds its value between spikes.
- Window counter wcnt: counts 0..WINDOW-1 on enabled cycles, then wraps to 0.
- Spike counter scnt, 16 bits:
  - += e, saturating at 16'hFFFF.
  - On the edge where wcnt == WINDOW-1: rate_count <= sat(scnt + e), then scnt <= 0. A spike detected on the closing edge belongs to the closing window.
- Rate handshake:
  - rate_valid is set on window close.
  - rate_valid is cleared on an edge with rate_valid && rate_ready, unless a window closes on that same edge. In that case it stays 1 with the new value; not an overrun.
  - A window close while rate_valid=1 and rate_ready=0: rate_count is overwritten and rate_overrun <= 1, held until rst.
  - rate_ready is ignored when rate_valid=0.
- en low:
  - spike and isi_valid are forced 0.
  - All counters, the FSM and rate_valid hold.
  - The handshake still completes on rate_ready.
- rst mid-operation: the next edge returns everything to reset values. A partial window is discarded and any pending rate_valid is dropped.

Test Plan (WINDOW=16, V_THRESH=200, V_REARM=64 unless noted):
- Reset/idle: rst 2 cycles, v_mem=0 for 40 cycles -> spike never 1. At cycles 16 and 32 after reset, rate_count=0 and rate_valid=1 (ready held 1). rate_overrun=0.
- Hysteresis: v_mem sequence 210,150,210,50,210 with each value held 3 cycles -> exactly 2 spike pulses, each 1 cycle after the first sample >= 200 following a re-arm.
- ISI: spikes injected at enabled cycles 5, 12, 30 -> no isi_valid on the first spike. isi=7 then isi=18 with isi_valid pulses.
- Window boundary: spike event lands on the edge with wcnt=15 -> it is counted in that window's rate_count; the next window starts at 0.
- Overrun: rate_ready=0 for 2 windows with 3 then 5 spikes -> rate_count=5, rate_valid=1, rate_overrun=1. Then ready=1 for one cycle -> rate_valid=0 and rate_overrun stays 1.
- Enable gating plus reset mid-window: en=0 for 10 cycles mid-window -> window and ISI stretch by 10 cycles. Assert rst at wcnt=8 -> all outputs 0 next cycle; the next rate_valid arrives 16 enabled cycles later.
